// File: rtl/pattern_search_engine_pkg.sv
// Shared types and default sizing for the pattern search engine.
package pse_pkg;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_MAX_PAT_LEN = 16;
    localparam int DEF_MEM_LAT     = 1;

    typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, EMIT, DONE} state_t;
endpackage

// File: rtl/pattern_search_engine_if.sv
// BRAM read port plus match result stream of the pattern search engine.
interface pattern_search_engine_if
    import pse_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              match_valid;
    logic [ADDR_W-1:0] match_addr;
    logic              match_ready;

    modport master (output mem_rd, mem_addr, match_valid, match_addr,
                    input  mem_rdata, match_ready);
    modport slave  (input  mem_rd, mem_addr, match_valid, match_addr,
                    output mem_rdata, match_ready);
endinterface

// File: rtl/pattern_search_engine_mem_reader.sv
// Single-outstanding BRAM reader: registers the strobe/address and flags the
// cycle in which read data is valid, MEM_LAT cycles after the strobe.
module pse_mem_reader
    import pse_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt;
    logic          pend;

    assign rdata_valid = pend && (cnt == CW'(MEM_LAT));
    assign rdata       = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
        end else begin
            mem_rd <= req;
            if (req) begin
                mem_addr <= addr;
                pend     <= 1'b1;
                cnt      <= '0;
            end else if (rdata_valid) begin
                pend <= 1'b0;
            end else if (pend) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/pattern_search_engine.sv
// Loads a pattern from BRAM then scans a block for every (overlapping) match.
// Optional match counter output enabled by PSE_MATCH_COUNT_EN.
module pattern_search_engine
    import pse_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int MAX_PAT_LEN = DEF_MAX_PAT_LEN,
    parameter int MEM_LAT     = DEF_MEM_LAT
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        pat_addr,
    input  logic [ADDR_W-1:0]        pat_len,
    input  logic [ADDR_W-1:0]        blk_addr,
    input  logic [ADDR_W-1:0]        blk_len,
    pattern_search_engine_if.master  bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err
`ifdef PSE_MATCH_COUNT_EN
    , output logic [ADDR_W-1:0]      match_count
`endif
);
    localparam int PW = (MAX_PAT_LEN > 1) ? $clog2(MAX_PAT_LEN) : 1;

    state_t            state;
    logic [ADDR_W-1:0] paddr, plen, baddr, last;
    logic [ADDR_W-1:0] i, j, k;
    logic [DATA_W-1:0] pat_buf [MAX_PAT_LEN];
    logic              match_valid;
    logic [ADDR_W-1:0] match_addr;

    logic              req, rdata_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic              job_ok, eq;
    logic [ADDR_W-1:0] plen_m1;

    assign job_ok  = (pat_len != '0) && (int'(pat_len) <= MAX_PAT_LEN) && (pat_len <= blk_len);
    assign plen_m1 = plen - ADDR_W'(1);
    assign eq      = (rdata == pat_buf[j[PW-1:0]]);

    assign bus.match_valid = match_valid;
    assign bus.match_addr  = match_addr;

    // Next read is issued on the same edge that consumes the previous data,
    // so every access costs exactly MEM_LAT+1 cycles.
    always_comb begin
        req     = 1'b0;
        rd_addr = '0;
        case (state)
            IDLE, DONE: if (start && job_ok) begin
                req     = 1'b1;
                rd_addr = pat_addr;
            end
            LOAD_PAT: if (rdata_valid) begin
                req     = 1'b1;
                rd_addr = (k == plen_m1) ? baddr : paddr + k + ADDR_W'(1);
            end
            SCAN: if (rdata_valid) begin
                if (!eq) begin
                    req     = (i != last);
                    rd_addr = baddr + i + ADDR_W'(1);
                end else if (j != plen_m1) begin
                    req     = 1'b1;
                    rd_addr = baddr + i + j + ADDR_W'(1);
                end
            end
            EMIT: if (bus.match_ready && i != last) begin
                req     = 1'b1;
                rd_addr = baddr + i + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    pse_mem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) u_reader (
        .clk         (CLK100MHZ),
        .reset       (reset),
        .req         (req),
        .addr        (rd_addr),
        .mem_rd      (bus.mem_rd),
        .mem_addr    (bus.mem_addr),
        .mem_rdata   (bus.mem_rdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            match_valid <= 1'b0;
            match_addr  <= '0;
            paddr       <= '0;
            plen        <= '0;
            baddr       <= '0;
            last        <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
`ifdef PSE_MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    paddr <= pat_addr;
                    plen  <= pat_len;
                    baddr <= blk_addr;
                    last  <= blk_len - pat_len;
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
`ifdef PSE_MATCH_COUNT_EN
                    match_count <= '0;
`endif
                    if (job_ok) begin
                        state <= LOAD_PAT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                LOAD_PAT: if (rdata_valid) begin
                    pat_buf[k[PW-1:0]] <= rdata;
                    k <= k + ADDR_W'(1);
                    if (k == plen_m1) state <= SCAN;
                end
                SCAN: if (rdata_valid) begin
                    if (!eq) begin
                        i <= i + ADDR_W'(1);
                        j <= '0;
                        if (i == last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (j == plen_m1) begin
                        state       <= EMIT;
                        match_valid <= 1'b1;
                        match_addr  <= baddr + i;
                    end else begin
                        j <= j + ADDR_W'(1);
                    end
                end
                EMIT: if (bus.match_ready) begin
                    match_valid <= 1'b0;
                    i <= i + ADDR_W'(1);
                    j <= '0;
`ifdef PSE_MATCH_COUNT_EN
                    if (match_count != '1) match_count <= match_count + ADDR_W'(1);
`endif
                    if (i == last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= SCAN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_search_engine.sv
// Self-checking bench: table of jobs against a reference scan of the memory
// model, plus back-pressure and mid-scan reset sequences.
module tb_pattern_search_engine;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] pat_addr, pat_len, blk_addr, blk_len;
    logic       busy, done, err;
`ifdef PSE_MATCH_COUNT_EN
    logic [7:0] match_count;
`endif

    pattern_search_engine_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    pattern_search_engine dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .start     (start),
        .pat_addr  (pat_addr),
        .pat_len   (pat_len),
        .blk_addr  (blk_addr),
        .blk_len   (blk_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef PSE_MATCH_COUNT_EN
        , .match_count (match_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int         rd_pulses = 0;

    // One-cycle-latency BRAM model
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            rd_pulses     <= rd_pulses + 1;
        end
    end

    typedef struct {
        logic [7:0] pa, pl, ba, bl;
        logic       err;
        int         n;      // expected match count, -1 = taken from model only
    } job_t;

    job_t       jobs [8];
    logic [7:0] exp_q [$];
    int         checks = 0, errors = 0, seen = 0;
    int         rd_base, seen_base;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sample at negedge, then return just after the next posedge
    task automatic tick();
        @(negedge clk);
        if (!reset && bus.match_valid && bus.match_ready) begin
            seen++;
            if (exp_q.size() == 0) check("match_unexpected", {24'b0, bus.match_addr}, 32'hFFFF_FFFF);
            else check("match_addr", {24'b0, bus.match_addr}, {24'b0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model(input job_t jb);
        for (int ii = 0; ii <= int'(jb.bl) - int'(jb.pl); ii++) begin
            bit ok = 1'b1;
            for (int jj = 0; jj < int'(jb.pl); jj++)
                if (mem[8'(int'(jb.ba) + ii + jj)] != mem[8'(int'(jb.pa) + jj)]) ok = 1'b0;
            if (ok) exp_q.push_back(8'(int'(jb.ba) + ii));
        end
    endtask

    task automatic start_job(input job_t jb);
        if (!jb.err) model(jb);
        rd_base   = rd_pulses;
        seen_base = seen;
        pat_addr  = jb.pa;
        pat_len   = jb.pl;
        blk_addr  = jb.ba;
        blk_len   = jb.bl;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (!jb.err) begin
            check("start_busy", {31'b0, busy}, 1);
            check("start_done_clr", {31'b0, done}, 0);
        end
`ifdef PSE_MATCH_COUNT_EN
        check("count_clr", {24'b0, match_count}, 0);
`endif
    endtask

    task automatic wait_done(input job_t jb);
        int t = 0;
        while (!done && t < 3000) begin
            tick();
            t++;
        end
        check("done", {31'b0, done}, 1);
        check("err", {31'b0, err}, {31'b0, jb.err});
        check("busy_end", {31'b0, busy}, 0);
        check("queue_left", exp_q.size(), 0);
        if (jb.n >= 0) check("match_total", seen - seen_base, jb.n);
        if (jb.err) check("rd_pulses", rd_pulses - rd_base, 0);
`ifdef PSE_MATCH_COUNT_EN
        if (jb.n >= 0) check("match_count", {24'b0, match_count}, jb.n);
`endif
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h10] = 8'h41; mem[8'h11] = 8'h42;
        begin
            logic [7:0] blk [8];
            blk = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h42, 8'h41, 8'h41, 8'h42};
            for (int a = 0; a < 8; a++) mem[8'h20 + a] = blk[a];
        end
        mem[8'h30] = 8'hAA; mem[8'h31] = 8'hBB;
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hAA; mem[8'h01] = 8'hBB;
        for (int a = 0; a < 3; a++)  mem[8'h40 + a] = 8'h41 + 8'($urandom_range(0, 1));
        for (int a = 0; a < 64; a++) mem[8'h80 + a] = 8'h41 + 8'($urandom_range(0, 1));

        jobs[0] = '{8'h10, 8'd2,  8'h20, 8'd8,  1'b0, 3};   // basic overlap
        jobs[1] = '{8'h30, 8'd2,  8'hFE, 8'd4,  1'b0, 2};   // wrap at top of memory
        jobs[2] = '{8'h10, 8'd0,  8'h20, 8'd8,  1'b1, 0};   // empty pattern
        jobs[3] = '{8'h10, 8'd17, 8'h20, 8'd20, 1'b1, 0};   // too long
        jobs[4] = '{8'h10, 8'd5,  8'h20, 8'd4,  1'b1, 0};   // longer than block
        jobs[5] = '{8'h40, 8'd3,  8'h80, 8'd64, 1'b0, -1};  // random block
        jobs[6] = '{8'h10, 8'd2,  8'h20, 8'd2,  1'b0, 1};   // single candidate
        jobs[7] = '{8'h80, 8'd16, 8'h80, 8'd16, 1'b0, 1};   // max pattern length

        reset = 1'b1; start = 1'b0; bus.match_ready = 1'b1;
        pat_addr = '0; pat_len = '0; blk_addr = '0; blk_len = '0;
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_mem_rd", {31'b0, bus.mem_rd}, 0);
        check("rst_mvalid", {31'b0, bus.match_valid}, 0);
        check("rst_mem_addr", {24'b0, bus.mem_addr}, 0);
        check("rst_maddr", {24'b0, bus.match_addr}, 0);
        reset = 1'b0;
        tick();

        for (int n = 0; n < 8; n++) begin
            start_job(jobs[n]);
            wait_done(jobs[n]);
            tick();
        end

        // Back-pressure on first match
        bus.match_ready = 1'b0;
        start_job(jobs[0]);
        begin
            int t = 0;
            while (!bus.match_valid && t < 200) begin
                tick();
                t++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", {31'b0, bus.match_valid}, 1);
            check("bp_addr", {24'b0, bus.match_addr}, 32'h20);
            check("bp_mem_rd", {31'b0, bus.mem_rd}, 0);
            tick();
        end
        bus.match_ready = 1'b1;
        wait_done(jobs[0]);
        tick();

        // Reset in the middle of the scan
        start_job(jobs[0]);
        for (int c = 0; c < 7; c++) tick();
        check("pre_rst_busy", {31'b0, busy}, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        check("mid_rst_err", {31'b0, err}, 0);
        check("mid_rst_mem_rd", {31'b0, bus.mem_rd}, 0);
        check("mid_rst_mvalid", {31'b0, bus.match_valid}, 0);
        check("mid_rst_mem_addr", {24'b0, bus.mem_addr}, 0);
        check("mid_rst_maddr", {24'b0, bus.match_addr}, 0);
        reset = 1'b0;
        exp_q.delete();
        tick();
        start_job(jobs[0]);
        wait_done(jobs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_search_engine.md
Name: pattern_search_engine

Overview:
- Parametrised successor to the team's single-byte BRAM pattern searcher.
- Loads a pattern of up to MAX_PAT_LEN words from memory into an internal buffer, then scans a memory block for every occurrence, overlapping occurrences included.
- Reports each match address over a valid/ready stream and signals completion.
- Sits between the top-level control and a single-port block RAM; the BRAM instance lives outside this block.

Parameters:
- DATA_W, 8: memory word width in bits.
- ADDR_W, 8: memory address width in bits.
- MAX_PAT_LEN, 16: pattern buffer depth in words.
- MEM_LAT, 1: BRAM read latency in cycles, >= 1.

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a job, sampled only in IDLE or DONE.
- pat_addr  in  ADDR_W  pattern base address.
- pat_len  in  ADDR_W  pattern length in words.
- blk_addr  in  ADDR_W  block base address.
- blk_len  in  ADDR_W  block length in words.
- mem_rd  out  1  read strobe to BRAM (drives ena).
- mem_addr  out  ADDR_W  BRAM address.
- mem_rdata  in  DATA_W  BRAM read data.
- match_valid  out  1  match address available.
- match_addr  out  ADDR_W  absolute address of match start.
- match_ready  in  1  consumer accepts match.
- busy  out  1  job in progress.
- done  out  1  job finished; held until next start or reset.
- err  out  1  job rejected; valid while done=1.

Behaviour:
- Reset (synchronous, active-high, on CLK100MHZ edge): state=IDLE; mem_rd, match_valid, busy, done, err=0; mem_addr, match_addr=0. A reset mid-job abandons the job immediately with no further reads or matches.
- start is latched with all inputs on the cycle it is seen in IDLE or DONE. This clears done and err and sets busy the next cycle. start is ignored while busy=1.
- Validation at start:
  - Reject if pat_len==0, pat_len>MAX_PAT_LEN, or pat_len>blk_len.
  - On rejection, go straight to DONE with err=1 and issue no reads.
- Memory protocol:
  - Exactly one read outstanding at a time.
  - mem_rd=1 for one cycle with mem_addr; mem_rdata is sampled MEM_LAT cycles later.
  - mem_rd=0 otherwise.
- All address arithmetic is modulo 2^ADDR_W; a block crossing the top of memory wraps to 0.
- States:
  - IDLE: wait for start.
  - LOAD_PAT: read pat_addr+k for k=0..pat_len-1 into pattern buffer entry k; then go to SCAN with i=0, j=0.
  - SCAN: read blk_addr+i+j and compare with buffer entry j.
    - Mismatch: i<=i+1, j<=0.
    - Match with j<pat_len-1: j<=j+1.
    - Match with j==pat_len-1: go to EMIT.
  - EMIT: match_valid=1, match_addr=blk_addr+i.
    - Hold match_addr stable until match_valid&&match_ready.
    - On that handshake cycle: i<=i+1, j<=0, return to SCAN. Back-pressure stalls the scan.
  - Candidate positions are i=0..blk_len-pat_len inclusive. When i exceeds blk_len-pat_len, go to DONE.
  - DONE: done=1, busy=0; wait for start.
- Matches are emitted in ascending i order, each position at most once.
- Pattern data is not cached across jobs; every start reloads the pattern.
- Latency:
  - Pattern load: pat_len*(MEM_LAT+1) cycles.
  - Each comparison: MEM_LAT+1 cycles.
  - EMIT: >=1 cycle.

Optional Feature:
- Macro PSE_MATCH_COUNT_EN.
- When defined:
  - Adds output match_count [ADDR_W] (note: ADDR_W bits suffice because at most blk_len-pat_len+1 positions can match).
  - match_count is cleared on reset and on accepted start.
  - It increments on each match handshake and saturates at all-ones.
  - It holds its final value in DONE.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package pse_pkg: state enum (IDLE, LOAD_PAT, SCAN, EMIT, DONE) and the default parameter constants.
- Natural sub-module: pse_mem_reader. It issues a single read, runs the MEM_LAT delay counter, and returns rdata_valid; it is used by both LOAD_PAT and SCAN.
- Pattern buffer is a local register array inside the top module.

Test Plan:
- Basic overlap:
  - Setup: memory[0x10..0x11]=41 42; memory[0x20..0x27]=41 42 41 42 42 41 41 42; pat_addr=0x10, pat_len=2, blk_addr=0x20, blk_len=8; match_ready=1.
  - Expect: matches 0x20, 0x22, 0x26; then done=1, err=0.
- Back-pressure:
  - Setup: same job, match_ready=0 for 10 cycles at the first match.
  - Expect: match_valid held with match_addr=0x20 stable; mem_rd=0 while stalled; final match list unchanged.
- Boundary and wrap:
  - Setup: pattern AA BB; memory[0xFE]=AA, memory[0xFF]=BB, memory[0x00]=AA, memory[0x01]=BB; blk_addr=0xFE, blk_len=4.
  - Expect: matches 0xFE and 0x00; the last candidate i=2 is checked.
- Rejection:
  - Setup: pat_len=0; then pat_len=17; then pat_len=5 with blk_len=4.
  - Expect: each gives done=1, err=1, zero mem_rd pulses.
- Reset mid-scan:
  - Setup: assert reset for 1 cycle during SCAN.
  - Expect: next cycle all outputs are 0 and state is IDLE; a new start then runs correctly.
- Counter (with PSE_MATCH_COUNT_EN):
  - Setup: run the basic overlap job.
  - Expect: match_count=3 at done; it clears to 0 on the next start.
